// File: rtl/regwr_pkg.sv
// Shared types and constants for the two-requester register-write arbiter.
package regwr_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    // Round-robin pointer encoding; also the last_grant encoding.
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WRITE,
        SETTLE
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances past the winner.
module rr_arbiter2
    import regwr_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == PTR_A) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= PTR_A;
        end else if (advance && (|req)) begin
            ptr <= grant[0] ? PTR_B : PTR_A;
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Arbitrates two write requesters onto a two-register file write port,
// one write per GRANT/WRITE/SETTLE sequence.
module regwr_arbiter
    import regwr_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_sel,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_sel,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    output logic              rf_write_enable,
    output logic [2:0]        rf_read_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy,
    output logic              last_grant,
    output logic [DATA_W-1:0] wr_count
);

    state_t            state;
    logic              sample;
    logic [1:0]        grant;
    logic              ptr;
    logic              hold_sel;
    logic [DATA_W-1:0] hold_data;

    // Requests are only looked at when the write port is free for a new grant.
    assign sample = (state == IDLE) || (state == SETTLE);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({b_req, a_req}),
        .advance (sample),
        .grant   (grant),
        .ptr     (ptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            a_ack           <= 1'b0;
            b_ack           <= 1'b0;
            rf_write_enable <= 1'b0;
            hold_sel        <= 1'b0;
            hold_data       <= '0;
            last_grant      <= PTR_A;
            wr_count        <= '0;
        end else begin
            a_ack           <= 1'b0;
            b_ack           <= 1'b0;
            rf_write_enable <= 1'b0;
            case (state)
                IDLE, SETTLE: begin
                    if (|grant) begin
                        state      <= GRANT;
                        a_ack      <= grant[0];
                        b_ack      <= grant[1];
                        hold_sel   <= grant[0] ? a_sel : b_sel;
                        hold_data  <= grant[0] ? a_data : b_data;
                        last_grant <= grant[1] ? PTR_B : PTR_A;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    state           <= WRITE;
                    rf_write_enable <= 1'b1;
                    wr_count        <= wr_count + DATA_W'(1);
                end
                WRITE: begin
                    state <= SETTLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign rf_read_reg   = {hold_sel, 2'b00};
    assign rf_write_data = hold_data;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Randomized and directed checks of regwr_arbiter against a cycle-age reference model.
module tb_regwr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       a_req = 1'b0, a_sel = 1'b0, b_req = 1'b0, b_sel = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ack, b_ack, rf_write_enable, busy, last_grant;
    logic [2:0] rf_read_reg;
    logic [7:0] rf_write_data, wr_count;

    int tests = 0;
    int fails = 0;

    regwr_arbiter #(.DATA_W(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .a_req           (a_req),
        .a_sel           (a_sel),
        .a_data          (a_data),
        .a_ack           (a_ack),
        .b_req           (b_req),
        .b_sel           (b_sel),
        .b_data          (b_data),
        .b_ack           (b_ack),
        .rf_write_enable (rf_write_enable),
        .rf_read_reg     (rf_read_reg),
        .rf_write_data   (rf_write_data),
        .busy            (busy),
        .last_grant      (last_grant),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    // Model: cycles since the last grant (-1 = no transaction in progress).
    int         m_age;
    bit         m_ptr, m_win, m_hsel, m_lastg;
    logic [7:0] m_hdata, m_cnt;
    logic [7:0] m_rf [2];
    logic [7:0] d_rf [2];
    int         writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = -1; m_ptr = 0; m_win = 0; m_hsel = 0; m_hdata = '0; m_lastg = 0; m_cnt = '0;
    endtask

    task automatic model_edge();
        if (m_age == -1 || m_age == 2) begin
            if (a_req || b_req) begin
                m_win   = (a_req && b_req) ? m_ptr : b_req;
                m_ptr   = !m_win;
                m_lastg = m_win;
                m_hsel  = m_win ? b_sel : a_sel;
                m_hdata = m_win ? b_data : a_data;
                m_age   = 0;
            end else begin
                m_age = -1;
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_cnt = m_cnt + 8'd1;
                m_rf[m_hsel] = m_hdata;
            end
        end
    endtask

    task automatic compare();
        check("a_ack", a_ack, m_age == 0 && !m_win);
        check("b_ack", b_ack, m_age == 0 && m_win);
        check("write_enable", rf_write_enable, m_age == 1);
        check("busy", busy, m_age != -1);
        check("read_reg", rf_read_reg, {m_hsel, 2'b00});
        check("write_data", rf_write_data, m_hdata);
        check("last_grant", last_grant, m_lastg);
        check("wr_count", wr_count, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (rf_write_enable) begin
            d_rf[rf_read_reg[2]] = rf_write_data;
            writes++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        reset_n = 1'b1;
        writes = 0;
    endtask

    initial begin
        int n_grants;
        int g_win [4];
        int g_cyc [4];
        int cyc;
        int acks;
        logic [7:0] reg1_first;
        bit a_pend, b_pend;

        m_rf[0] = '0; m_rf[1] = '0; d_rf[0] = '0; d_rf[1] = '0;
        writes = 0;

        // Single write latency
        do_reset();
        a_req = 1'b1; a_sel = 1'b0; a_data = 8'h5A;
        step();
        check("lat_ack", a_ack, 1'b1);
        a_req = 1'b0;
        step();
        check("lat_we", rf_write_enable, 1'b1);
        check("lat_reg", rf_read_reg, 3'b000);
        check("lat_data", rf_write_data, 8'h5A);
        check("lat_count", wr_count, 8'd1);
        step(); step();

        // Both held high: alternating grants every 3 cycles
        do_reset();
        a_req = 1'b1; a_sel = 1'b0; a_data = 8'hA1;
        b_req = 1'b1; b_sel = 1'b1; b_data = 8'hB2;
        n_grants = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if ((a_ack || b_ack) && n_grants < 4) begin
                g_win[n_grants] = b_ack;
                g_cyc[n_grants] = i;
                n_grants++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        check("rr_ngrants", n_grants, 4);
        for (int i = 0; i < 4 && i < n_grants; i++) begin
            check("rr_winner", g_win[i], i % 2);
            if (i > 0) check("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        step(); step(); step();

        // Same register from both: arbitration order, B's data final
        do_reset();
        writes = 0;
        a_req = 1'b1; a_sel = 1'b1; a_data = 8'h11;
        b_req = 1'b1; b_sel = 1'b1; b_data = 8'h22;
        reg1_first = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rf_write_enable && writes == 1) reg1_first = rf_write_data;
            if (a_ack) a_req = 1'b0;
            if (b_ack) b_req = 1'b0;
        end
        check("same_writes", writes, 2);
        check("same_first", reg1_first, 8'h11);
        check("same_final", d_rf[1], 8'h22);

        // Reset during WRITE aborts everything
        do_reset();
        a_req = 1'b1; a_sel = 1'b1; a_data = 8'h77;
        step();
        a_req = 1'b0;
        step();
        check("abort_in_write", rf_write_enable, 1'b1);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("abort_we", rf_write_enable, 1'b0);
        check("abort_count", wr_count, 8'd0);
        check("abort_busy", busy, 1'b0);
        compare();
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_ack || b_ack) acks++;
        end
        check("abort_noack", acks, 0);

        // Short A pulse while busy outside SETTLE is ignored
        do_reset();
        b_req = 1'b1; b_sel = 1'b0; b_data = 8'h33;
        step();
        b_req = 1'b0;
        a_req = 1'b1; a_sel = 1'b0; a_data = 8'h44;
        step();
        a_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_ack) acks++;
        end
        check("pulse_noack", acks, 0);
        check("pulse_writes", writes, 1);

        // 256 sequential B writes wrap the counter
        do_reset();
        b_req = 1'b1; b_sel = 1'b0;
        cyc = 0;
        while (writes < 256 && cyc < 1000) begin
            b_data = 8'($urandom);
            step();
            cyc++;
        end
        b_req = 1'b0;
        check("wrap_bound", writes, 256);
        check("wrap_count", wr_count, 8'h00);
        step(); step();

        // Randomized traffic following the hold-until-ack protocol
        do_reset();
        a_pend = 0; b_pend = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (a_ack) a_pend = 0;
            if (b_ack) b_pend = 0;
            if (!a_pend) begin
                a_pend = ($urandom_range(0, 2) == 0);
                a_req  = a_pend;
                a_sel  = 1'($urandom);
                a_data = 8'($urandom);
            end
            if (!b_pend) begin
                b_pend = ($urandom_range(0, 2) == 0);
                b_req  = b_pend;
                b_sel  = 1'($urandom);
                b_data = 8'($urandom);
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        step(); step(); step(); step();
        check("rf0_final", d_rf[0], m_rf[0]);
        check("rf1_final", d_rf[1], m_rf[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
